ex_mdu: RTL and testbench

//  Iterative multiply/divide unit for the EX stage. Runs MULT/MULTU/DIV/DIVU over several cycles.

---
 rtl/ex_mdu_if.sv | 17 +
 rtl/ex_mdu.sv | 154 +++++++++++++++
 tb/tb_ex_mdu.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
interface ex_mdu_if #(parameter int BUS_SIZE = 32);
    logic                i_flush;
    logic                i_start;
    logic [2:0]          i_op;
    logic [BUS_SIZE-1:0] i_data_a;
    logic [BUS_SIZE-1:0] i_data_b;
    logic                o_busy;
    logic                o_done;
    logic [BUS_SIZE-1:0] o_hi;
    logic [BUS_SIZE-1:0] o_lo;

    modport master (output i_flush, i_start, i_op, i_data_a, i_data_b,
                    input  o_busy, o_done, o_hi, o_lo);
    modport slave  (input  i_flush, i_start, i_op, i_data_a, i_data_b,
                    output o_busy, o_done, o_hi, o_lo);
endinterface

// File: rtl/ex_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; also executes MTHI/MTLO.
// Divider datapath is only built when EX_MDU_DIV_EN is defined.
module ex_mdu #(
    parameter int BUS_SIZE       = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic      i_clk,
    input  logic      i_reset,
    ex_mdu_if.slave   bus
);
    localparam int N  = BUS_SIZE / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [2*BUS_SIZE-1:0] acc, acc_nxt;
    logic [BUS_SIZE-1:0]   opnd;
    logic                  is_div_r, sgn_a, sgn_b;
    logic                  busy_r, done_r;
    logic [BUS_SIZE-1:0]   hi_r, lo_r;

    logic                  op_mul, op_div, op_signed;
    logic [BUS_SIZE-1:0]   mag_a, mag_b;
    logic [BUS_SIZE:0]     sum;
    logic [2*BUS_SIZE-1:0] prod_fix;
    logic [BUS_SIZE-1:0]   quo, rem, div_lo, div_hi;

    assign op_mul    = (bus.i_op == OP_MULT) || (bus.i_op == OP_MULTU);
`ifdef EX_MDU_DIV_EN
    assign op_div    = (bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU);
`else
    assign op_div    = 1'b0;
`endif
    assign op_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
    assign mag_a     = (op_signed && bus.i_data_a[BUS_SIZE-1]) ? -bus.i_data_a : bus.i_data_a;
    assign mag_b     = (op_signed && bus.i_data_b[BUS_SIZE-1]) ? -bus.i_data_b : bus.i_data_b;

`ifdef EX_MDU_DIV_EN
    logic [BUS_SIZE:0] trial;
`endif

    // acc holds {upper,multiplier} for multiply (shifts right) and {rem,quotient} for divide (shifts left).
    always_comb begin
        acc_nxt = acc;
        sum     = '0;
`ifdef EX_MDU_DIV_EN
        trial   = '0;
`endif
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (is_div_r) begin
`ifdef EX_MDU_DIV_EN
                trial = acc_nxt[2*BUS_SIZE-1:BUS_SIZE-1] - {1'b0, opnd};
                if (!trial[BUS_SIZE])
                    acc_nxt = {trial[BUS_SIZE-1:0], acc_nxt[BUS_SIZE-2:0], 1'b1};
                else
                    acc_nxt = {acc_nxt[2*BUS_SIZE-2:0], 1'b0};
`endif
            end else begin
                sum     = {1'b0, acc_nxt[2*BUS_SIZE-1:BUS_SIZE]} +
                          (acc_nxt[0] ? {1'b0, opnd} : '0);
                acc_nxt = {sum, acc_nxt[BUS_SIZE-1:1]};
            end
        end
    end

    // A zero divisor leaves the quotient all ones and the remainder equal to the dividend;
    // the remainder's dividend-sign fix restores the raw i_data_a, only LO needs overriding.
    assign prod_fix = (sgn_a ^ sgn_b) ? -acc : acc;
    assign quo      = acc[BUS_SIZE-1:0];
    assign rem      = acc[2*BUS_SIZE-1:BUS_SIZE];
    assign div_lo   = (opnd == '0) ? '1 : ((sgn_a ^ sgn_b) ? -quo : quo);
    assign div_hi   = sgn_a ? -rem : rem;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div_r <= 1'b0;
            sgn_a    <= 1'b0;
            sgn_b    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_start && !bus.i_flush) begin
                        if (op_mul || op_div) begin
                            state    <= S_CALC;
                            busy_r   <= 1'b1;
                            cnt      <= '0;
                            is_div_r <= op_div;
                            sgn_a    <= op_signed && bus.i_data_a[BUS_SIZE-1];
                            sgn_b    <= op_signed && bus.i_data_b[BUS_SIZE-1];
                            opnd     <= op_div ? mag_b : mag_a;
                            acc      <= {{BUS_SIZE{1'b0}}, (op_div ? mag_a : mag_b)};
                        end else if (bus.i_op == OP_MTHI) begin
                            hi_r <= bus.i_data_a;
                        end else if (bus.i_op == OP_MTLO) begin
                            lo_r <= bus.i_data_a;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.i_flush) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(N - 1))
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    if (!bus.i_flush) begin
                        done_r <= 1'b1;
                        if (is_div_r) begin
                            hi_r <= div_hi;
                            lo_r <= div_lo;
                        end else begin
                            hi_r <= prod_fix[2*BUS_SIZE-1:BUS_SIZE];
                            lo_r <= prod_fix[BUS_SIZE-1:0];
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy = busy_r;
    assign bus.o_done = done_r;
    assign bus.o_hi   = hi_r;
    assign bus.o_lo   = lo_r;
endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: one 32/1 instance plus a 32/4 instance for the faster multiply.
module tb_ex_mdu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mdu_if #(.BUS_SIZE(32)) m1();
    ex_mdu_if #(.BUS_SIZE(32)) m4();

    ex_mdu #(.BUS_SIZE(32), .BITS_PER_CYCLE(1)) u1 (.i_clk(clk), .i_reset(rst), .bus(m1));
    ex_mdu #(.BUS_SIZE(32), .BITS_PER_CYCLE(4)) u4 (.i_clk(clk), .i_reset(rst), .bus(m4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 32/1 unit and wait for o_done; reports the done edge and whether busy held.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int done_edge, output bit busy_ok);
        @(negedge clk);
        m1.i_start = 1'b1; m1.i_op = op; m1.i_data_a = a; m1.i_data_b = b;
        @(posedge clk); #1;
        busy_ok = m1.o_busy;
        @(negedge clk);
        m1.i_start = 1'b0; m1.i_data_a = 32'h1234_5678; m1.i_data_b = 32'h0BAD_F00D;
        done_edge = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (m1.o_done) begin done_edge = e; break; end
            if (!m1.o_busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int  de;
        bit  bok;
        bit  saw;
        m1.i_flush = 0; m1.i_start = 0; m1.i_op = 0; m1.i_data_a = 0; m1.i_data_b = 0;
        m4.i_flush = 0; m4.i_start = 0; m4.i_op = 0; m4.i_data_a = 0; m4.i_data_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", m1.o_busy, 0);
        chk("rst_done", m1.o_done, 0);
        chk("rst_hi", m1.o_hi, 0);
        chk("rst_lo", m1.o_lo, 0);
        @(negedge clk); rst = 1'b0;

        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, de, bok);
        chk("mult_edge", de, 33);
        chk("mult_busy_held", bok, 1);
        chk("mult_busy_at_done", m1.o_busy, 0);
        chk("mult_hi", m1.o_hi, 32'hFFFF_FFFF);
        chk("mult_lo", m1.o_lo, 32'hFFFF_FFEB);
        @(posedge clk); #1;
        chk("mult_done_pulse", m1.o_done, 0);

        run_op(3'b001, 32'hFFFF_FFFF, 32'd2, de, bok);
        chk("multu_hi", m1.o_hi, 32'h0000_0001);
        chk("multu_lo", m1.o_lo, 32'hFFFF_FFFE);

        // 4 bits per cycle: same product, done at edge 9
        @(negedge clk);
        m4.i_start = 1'b1; m4.i_op = 3'b001; m4.i_data_a = 32'hFFFF_FFFF; m4.i_data_b = 32'd2;
        @(posedge clk); #1;
        chk("multu4_busy", m4.o_busy, 1);
        @(negedge clk); m4.i_start = 1'b0; m4.i_data_a = 0; m4.i_data_b = 0;
        de = -1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (m4.o_done) begin de = e; break; end
        end
        chk("multu4_edge", de, 9);
        chk("multu4_hi", m4.o_hi, 32'h0000_0001);
        chk("multu4_lo", m4.o_lo, 32'hFFFF_FFFE);

`ifdef EX_MDU_DIV_EN
        run_op(3'b011, 32'd100, 32'd7, de, bok);
        chk("divu_edge", de, 33);
        chk("divu_lo", m1.o_lo, 32'd14);
        chk("divu_hi", m1.o_hi, 32'd2);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, de, bok);
        chk("div_lo", m1.o_lo, 32'hFFFF_FFFD);
        chk("div_hi", m1.o_hi, 32'hFFFF_FFFF);
        run_op(3'b011, 32'd5, 32'd0, de, bok);
        chk("divz_edge", de, 33);
        chk("divz_lo", m1.o_lo, 32'hFFFF_FFFF);
        chk("divz_hi", m1.o_hi, 32'd5);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, de, bok);
        chk("divovf_lo", m1.o_lo, 32'h8000_0000);
        chk("divovf_hi", m1.o_hi, 32'd0);
`endif

        // DIVU request while a MULTU is in flight must be dropped
        @(negedge clk);
        m1.i_start = 1'b1; m1.i_op = 3'b001; m1.i_data_a = 32'h0001_0000; m1.i_data_b = 32'h0001_0000;
        @(posedge clk);
        @(negedge clk);
        m1.i_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m1.i_start = 1'b1; m1.i_op = 3'b011; m1.i_data_a = 32'd9; m1.i_data_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        m1.i_start = 1'b0;
        de = -1;
        for (int e = 4; e <= 60; e++) begin
            @(posedge clk); #1;
            if (m1.o_done) begin de = e; break; end
        end
        chk("ign_edge", de, 33);
        chk("ign_hi", m1.o_hi, 32'h0000_0001);
        chk("ign_lo", m1.o_lo, 32'h0000_0000);
        saw = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (m1.o_done || m1.o_busy) saw = 1'b1;
        end
        chk("ign_no_second_op", saw, 0);

        // MTHI then MTLO back to back
        @(negedge clk);
        m1.i_start = 1'b1; m1.i_op = 3'b100; m1.i_data_a = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        chk("mthi_hi", m1.o_hi, 32'hA5A5_A5A5);
        chk("mthi_busy", m1.o_busy, 0);
        @(negedge clk);
        m1.i_op = 3'b101; m1.i_data_a = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        chk("mtlo_lo", m1.o_lo, 32'h5A5A_5A5A);
        chk("mtlo_hi_kept", m1.o_hi, 32'hA5A5_A5A5);
        chk("mtlo_done", m1.o_done, 0);
        @(negedge clk); m1.i_start = 1'b0;

`ifndef EX_MDU_DIV_EN
        @(negedge clk);
        m1.i_start = 1'b1; m1.i_op = 3'b010; m1.i_data_a = 32'd100; m1.i_data_b = 32'd7;
        @(posedge clk); #1;
        chk("nodiv_busy", m1.o_busy, 0);
        @(negedge clk); m1.i_start = 1'b0;
        saw = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (m1.o_done || m1.o_busy) saw = 1'b1;
        end
        chk("nodiv_quiet", saw, 0);
        chk("nodiv_hi", m1.o_hi, 32'hA5A5_A5A5);
        chk("nodiv_lo", m1.o_lo, 32'h5A5A_5A5A);
`endif

        // Flush sampled at edge 10 of a MULT
        @(negedge clk);
        m1.i_start = 1'b1; m1.i_op = 3'b000; m1.i_data_a = 32'd3; m1.i_data_b = 32'd3;
        @(posedge clk);
        @(negedge clk); m1.i_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); m1.i_flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_busy", m1.o_busy, 0);
        @(negedge clk); m1.i_flush = 1'b0;
        saw = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (m1.o_done) saw = 1'b1;
        end
        chk("flush_no_done", saw, 0);
        chk("flush_hi", m1.o_hi, 32'hA5A5_A5A5);
        chk("flush_lo", m1.o_lo, 32'h5A5A_5A5A);

        // Reset sampled at edge 5 of a MULT
        @(negedge clk);
        m1.i_start = 1'b1; m1.i_op = 3'b000; m1.i_data_a = 32'd3; m1.i_data_b = 32'd3;
        @(posedge clk);
        @(negedge clk); m1.i_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", m1.o_busy, 0);
        chk("mrst_done", m1.o_done, 0);
        chk("mrst_hi", m1.o_hi, 0);
        chk("mrst_lo", m1.o_lo, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
